// File: rtl/aes_decripta_pkg.sv
// Shared types, constants and helpers for the iterative AES-128 decryptor.
// State is row-major: byte k sits at [127-8k -: 8], row k/4, column k%4.
package aes_decripta_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        OCIOSO,
        RODADA,
        FINAL,
        PRONTO
    } estado_fsm_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Row r is rotated right by r bytes.
    function automatic logic [127:0] inv_shift_rows(
        input logic [127:0] s
    );
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r*4+c) -: 8] =
                    s[127-8*(r*4+((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/decripta_iterativo_if.sv
// Block, plaintext and round-key signals of the AES decryptor.
// master = block source / key store side, slave = the core.
interface decripta_iterativo_if;

    logic         entrada_valida;
    logic         entrada_pronta;
    logic [127:0] bloco;
    logic [3:0]   chave_idx;
    logic [127:0] chave_rodada;
    logic         saida_valida;
    logic         saida_pronta;
    logic [127:0] saida;

    modport master (
        output entrada_valida,
        output bloco,
        output chave_rodada,
        output saida_pronta,
        input  entrada_pronta,
        input  chave_idx,
        input  saida_valida,
        input  saida
    );

    modport slave (
        input  entrada_valida,
        input  bloco,
        input  chave_rodada,
        input  saida_pronta,
        output entrada_pronta,
        output chave_idx,
        output saida_valida,
        output saida
    );

endinterface

// File: rtl/multiplicaColunas.sv
// InvMixColumns over a row-major 128-bit state.
module multiplicaColunas (
    input  logic [127:0] estado,
    output logic [127:0] resultado
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse coefficients 9, b, d, e built from doublings.
    function automatic logic [31:0] mix_col(
        input logic [31:0] col
    );
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2[r] = xt(a[r]);
            x4[r] = xt(x2[r]);
            x8[r] = xt(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        return {
            me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]
        };
    endfunction

    always_comb begin
        logic [31:0] col;
        logic [31:0] mix;
        resultado = '0;
        col = '0;
        mix = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                col[31-8*r -: 8] = estado[127-8*(r*4+c) -: 8];
            end
            mix = mix_col(col);
            for (int r = 0; r < 4; r++) begin
                resultado[127-8*(r*4+c) -: 8] = mix[31-8*r -: 8];
            end
        end
    end

endmodule

// File: rtl/sbox_inversa.sv
// Single-byte inverse S-box, combinational table lookup.
module sbox_inversa
    import aes_decripta_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = INV_SBOX[a];

endmodule

// File: rtl/decripta_iterativo.sv
// Iterative AES-128 decryption: one round per clock, 10 rounds per block.
module decripta_iterativo
    import aes_decripta_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    decripta_iterativo_if.slave  io
);

    estado_fsm_t  fsm;
    logic [127:0] estado;
    logic [3:0]   contador;
    logic [127:0] saida_r;
    logic         saida_valida_r;
    logic         entrada_pronta_r;
    logic [3:0]   chave_idx;

    logic [127:0] deslocado;
    logic [127:0] substituido;
    logic [127:0] com_chave;
    logic [127:0] misturado;

    assign deslocado = inv_shift_rows(estado);

    for (genvar k = 0; k < 16; k++) begin : g_sbox
        sbox_inversa u_sbox (
            .a (deslocado[127-8*k -: 8]),
            .y (substituido[127-8*k -: 8])
        );
    end

    assign com_chave = substituido ^ io.chave_rodada;

    // Mixed value feeds rounds 9..1; FINAL takes com_chave directly.
    multiplicaColunas u_mix (
        .estado    (com_chave),
        .resultado (misturado)
    );

    always_comb begin
        chave_idx = '0;
        unique case (1'b1)
            fsm == OCIOSO: chave_idx = 4'(NR);
            fsm == RODADA: chave_idx = contador;
            default:       chave_idx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm              <= OCIOSO;
            estado           <= '0;
            contador         <= '0;
            saida_r          <= '0;
            saida_valida_r   <= 1'b0;
            entrada_pronta_r <= 1'b0;
        end else begin
            unique case (fsm)
                OCIOSO: begin
                    entrada_pronta_r <= 1'b1;
                    if (io.entrada_valida && entrada_pronta_r) begin
                        estado           <= io.bloco ^ io.chave_rodada;
                        contador         <= 4'(NR - 1);
                        entrada_pronta_r <= 1'b0;
                        fsm              <= RODADA;
                    end
                end
                RODADA: begin
                    estado   <= misturado;
                    contador <= contador - 4'd1;
                    if (contador == 4'd1) begin
                        fsm <= FINAL;
                    end
                end
                FINAL: begin
                    saida_r        <= com_chave;
                    saida_valida_r <= 1'b1;
                    fsm            <= PRONTO;
                end
                PRONTO: begin
                    if (io.saida_pronta) begin
                        saida_valida_r   <= 1'b0;
                        entrada_pronta_r <= 1'b1;
                        fsm              <= OCIOSO;
                    end
                end
                default: fsm <= OCIOSO;
            endcase
        end
    end

    assign io.entrada_pronta = entrada_pronta_r;
    assign io.chave_idx      = chave_idx;
    assign io.saida_valida   = saida_valida_r;
    assign io.saida          = saida_r;

endmodule

// File: tb/tb_decripta_iterativo.sv
// Bench for decripta_iterativo: FIPS vectors, handshake corners, and
// random blocks produced by a forward AES model built from GF(2^8) math.
module tb_decripta_iterativo;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decripta_iterativo_if bus ();

    decripta_iterativo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    logic [127:0] rk [16];
    logic [7:0]   sbox [256];
    int n_cmp = 0;
    int n_bad = 0;

    assign bus.chave_rodada = rk[bus.chave_idx];

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        logic [3:0]   hold;
    } vec_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                    ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
        return s[127-8*(r*4+c) -: 8];
    endfunction

    // FIPS byte order (column-major) <-> row-major; an involution.
    function automatic logic [127:0] tr(input logic [127:0] x);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r*4+c) -: 8] = x[127-8*(c*4+r) -: 8];
        return o;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
                  ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int rd = 0; rd < 16; rd++) rk[rd] = '0;
        for (int rd = 0; rd <= 10; rd++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    rk[rd][127-8*(r*4+c) -: 8] = w[4*rd+c][31-8*r -: 8];
    endtask

    // Forward cipher on a row-major state with the loaded schedule.
    function automatic logic [127:0] enc(input logic [127:0] p);
        logic [127:0] s;
        logic [127:0] t;
        logic [7:0]   a [4];
        s = p ^ rk[0];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[127-8*(r*4+c) -: 8] = sbox[gb(s, r, (c + r) % 4)];
            if (rd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = gb(t, r, c);
                    for (int r = 0; r < 4; r++)
                        t[127-8*(r*4+c) -: 8] =
                            gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03)
                          ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            s = t ^ rk[rd];
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_pronto(input string nm);
        int n;
        n = 0;
        while (bus.entrada_pronta !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " pronto"}, 128'(bus.entrada_pronta), 128'd1);
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [127:0] exp,
                             input int hold, input logic sp_busy, input string nm);
        int n;
        logic [3:0]   seq [$];
        logic [127:0] got;
        logic [127:0] want;
        wait_pronto(nm);
        seq.push_back(bus.chave_idx);
        bus.bloco = ct;
        bus.entrada_valida = 1'b1;
        @(negedge clk);
        bus.entrada_valida = 1'b0;
        bus.bloco = ~ct;
        bus.saida_pronta = sp_busy;
        n = 0;
        while (bus.saida_valida !== 1'b1 && n < 30) begin
            seq.push_back(bus.chave_idx);
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 128'(n), 128'd10);
        got = '0;
        want = '0;
        foreach (seq[i]) got = (got << 4) | 128'(seq[i]);
        for (int i = 0; i <= 10; i++) want = (want << 4) | 128'(10 - i);
        chk({nm, " chave_idx seq"}, got, want);
        chk({nm, " saida"}, bus.saida, exp);
        bus.saida_pronta = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, " hold saida"}, bus.saida, exp);
            chk({nm, " hold valida"}, 128'(bus.saida_valida), 128'd1);
            chk({nm, " hold pronta"}, 128'(bus.entrada_pronta), 128'd0);
        end
        bus.saida_pronta = 1'b1;
        @(negedge clk);
        bus.saida_pronta = 1'b0;
        chk({nm, " handoff valida"}, 128'(bus.saida_valida), 128'd0);
        chk({nm, " handoff pronta"}, 128'(bus.entrada_pronta), 128'd1);
        chk({nm, " saida kept"}, bus.saida, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vt [3];
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct2;
        logic [127:0] pt2;
        logic         busy_ok;
        int           n;

        vt[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734, 4'd0};
        vt[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff, 4'd5};
        vt[2] = '{128'h0,
                  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                  128'h0, 4'd0};

        bus.entrada_valida = 1'b0;
        bus.bloco = '0;
        bus.saida_pronta = 1'b0;
        rst_n = 1'b0;
        build_sbox();
        expand_key(vt[0].key);

        @(negedge clk);
        chk("reset saida", bus.saida, 128'd0);
        chk("reset valida", 128'(bus.saida_valida), 128'd0);
        chk("reset pronta", 128'(bus.entrada_pronta), 128'd0);
        chk("reset chave_idx", 128'(bus.chave_idx), 128'd10);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            expand_key(vt[i].key);
            run_block(tr(vt[i].ct), tr(vt[i].pt), int'(vt[i].hold), 1'b0,
                      $sformatf("vec%0d", i));
        end

        // entrada_valida stays high across a whole block and its handoff.
        expand_key(vt[1].key);
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        ct2 = enc(pt2);
        wait_pronto("stream");
        bus.bloco = tr(vt[1].ct);
        bus.entrada_valida = 1'b1;
        @(negedge clk);
        bus.bloco = ct2;
        busy_ok = 1'b1;
        n = 0;
        while (bus.saida_valida !== 1'b1 && n < 30) begin
            if (bus.entrada_pronta !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (bus.entrada_pronta !== 1'b0) busy_ok = 1'b0;
        chk("stream busy pronta low", 128'(busy_ok), 128'd1);
        chk("stream first latency", 128'(n), 128'd10);
        chk("stream first saida", bus.saida, tr(vt[1].pt));
        bus.saida_pronta = 1'b1;
        @(negedge clk);
        bus.saida_pronta = 1'b0;
        chk("stream idle pronta", 128'(bus.entrada_pronta), 128'd1);
        chk("stream idle valida", 128'(bus.saida_valida), 128'd0);
        @(negedge clk);
        chk("stream second accept", 128'(bus.entrada_pronta), 128'd0);
        bus.entrada_valida = 1'b0;
        n = 0;
        while (bus.saida_valida !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("stream second latency", 128'(n), 128'd10);
        chk("stream second saida", bus.saida, pt2);
        bus.saida_pronta = 1'b1;
        @(negedge clk);
        bus.saida_pronta = 1'b0;

        // Reset in the middle of a block discards it.
        expand_key(vt[0].key);
        wait_pronto("midreset");
        bus.bloco = tr(vt[0].ct);
        bus.entrada_valida = 1'b1;
        @(negedge clk);
        bus.entrada_valida = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset saida", bus.saida, 128'd0);
        chk("midreset valida", 128'(bus.saida_valida), 128'd0);
        chk("midreset pronta", 128'(bus.entrada_pronta), 128'd0);
        chk("midreset chave_idx", 128'(bus.chave_idx), 128'd10);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(tr(vt[0].ct), tr(vt[0].pt), 0, 1'b0, "after reset");

        for (int i = 0; i < 12; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            run_block(enc(pt), pt, int'($urandom_range(0, 2)), 1'(i % 2),
                      $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
